dma_priority_arbiter: RTL
=========================

// Module: dma_priority_arbiter
// PURPOSE
// - DMA channel priority arbiter, 8237-style.
// - Resolves DREQ hardware requests and software request-register bits into one serviced channel.
// - Raises the hold request toward timing control and drives DACK for the granted channel.
// - Sits between the bus-interface/register file (upstream) and dma_timing_control (downstream).
// - Owns the fixed/rotating priority order that the priorityOrder checks inspect.
// PARAMETERS
// - NUM_CH         4              channel count; only 4 supported
// - CH_W           2              channel index width
// - ORDER_DEFAULT  8'b11_10_01_00 reset/fixed priority order; field [1:0] = highest
// PORTS
// - CLK             in   1  system clock; single clock domain
// - RESET           in   1  synchronous, active-high reset
// - DREQ            in   4  raw channel DMA requests
// - dreqSense       in   1  commandReg DREQ polarity: 0 = active high, 1 = active low
// - priorityType    in   1  commandReg: 0 = fixed, 1 = rotating
// - dmaDisable      in   1  commandReg controller disable
// - maskReg         in   4  per-channel mask; 1 = masked (hardware DREQ only)
// - softReq         in   4  software request-register bits; ignore mask
// - HLDA            in   1  hold acknowledge from CPU
// - assertDACK      in   1  timing control in S1..S4 service window
// - transferDone    in   1  one-cycle pulse: service of active channel ends (TC, EOP or single transfer)
// - hrqReq          out  1  hold request to timing control / HRQ pin
// - DACK            out  4  one-hot, active-high acknowledge
// - activeChannel   out  2  granted channel index
// - channelValid    out  1  activeChannel meaningful (state != IDLE)
// - clearSoftReq    out  4  one-cycle pulse clearing the serviced softReq bit
// - priorityOrder   out  8  current order register
// BEHAVIOUR
// - Reset values:
//   - state = IDLE; hrqReq, DACK, channelValid, clearSoftReq = 0; activeChannel = 0
//   - priorityOrder = ORDER_DEFAULT
//   - reset mid-service aborts unconditionally; no clearSoftReq pulse is issued
// - pending = ((DREQ ^ {4{dreqSense}}) & ~maskReg) | softReq, evaluated combinationally each cycle
// - IDLE:
//   - if !dmaDisable and pending != 0: latch winner = first field of priorityOrder (from [1:0] up)
//     whose pending bit is set into activeChannel
//   - go REQ; hrqReq = 1 from the next cycle (1-cycle latency)
// - REQ:
//   - HLDA high -> GRANT
//   - else if pending[activeChannel] == 0 (request withdrawn) -> IDLE, hrqReq drops next cycle
//   - dmaDisable high -> IDLE
// - GRANT:
//   - hrqReq held 1
//   - DACK <= onehot(activeChannel) when assertDACK, else 0 (registered, 1-cycle latency)
//   - winner is frozen; new or higher-priority requests do not preempt
// - transferDone in GRANT -> IDLE:
//   - next cycle: hrqReq = 0, DACK = 0
//   - clearSoftReq[activeChannel] pulses if softReq[activeChannel] was set
// - Rotation on transferDone:
//   - priorityType == 1: serviced channel k becomes lowest; order = {k, k+3, k+2, k+1} mod 4,
//     e.g. served ch1 -> 8'b01_00_11_10
//   - priorityType == 0: order forced to ORDER_DEFAULT every cycle
// - HLDA fall while in GRANT without transferDone: treat as abort -> IDLE, no rotation, no clear
// - Simultaneous events:
//   - transferDone wins over new requests
//   - re-arbitration happens in the IDLE cycle after, using the updated order
//   - no back-to-back grant without one IDLE cycle
// - DACK is always one-hot or zero; never more than one bit set
// STRUCTURE
// - Shared package dma_pkg:
//   - arbState_t enum {IDLE, REQ, GRANT}
//   - ORDER_DEFAULT constant
//   - function rotateOrder(order, k)
// - Sub-module dma_priority_encoder (combinational): pending[3:0], order[7:0] -> winner[1:0], any
// - Top level holds the FSM, the order register and the DACK/clearSoftReq flops
// TESTING
// - Reset then DREQ = 4'b1010, fixed priority, mask 0
//   -> hrqReq at +1; HLDA -> DACK = 4'b0010 while assertDACK
// - DREQ = 4'b1111, rotating; service ch0, pulse transferDone
//   -> order = 8'b00_11_10_01; next grant DACK = 4'b0010
// - maskReg = 4'b0001, DREQ = 4'b0001, softReq = 0 -> hrqReq stays 0
// - Same masked setup, then softReq = 4'b0001 -> grant ch0; clearSoftReq = 4'b0001 on done
// - REQ state, DREQ drops before HLDA -> IDLE, hrqReq = 0 next cycle, DACK never asserted
// - RESET asserted in GRANT with DACK = 4'b0100
//   -> next cycle DACK = 0, hrqReq = 0, order = 8'b11_10_01_00

Source files
------------

// File: rtl/dma_pkg.sv
// ============================================================================
// Module : dma_pkg
// Brief  : Shared types, constants and priority-rotation helper for the DMA arbiter.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package dma_pkg;

    localparam int          NUM_CH        = 4;
    localparam int          CH_W          = 2;
    localparam logic [7:0]  ORDER_DEFAULT = 8'b11_10_01_00;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        GRANT = 2'd2
    } arbState_t;

    // Rotate the order so the field following channel k becomes highest
    // and k itself drops to the lowest slot.
    function automatic logic [7:0] rotateOrder(input logic [7:0] order,
                                               input logic [1:0] k);
        logic [1:0]  pos;
        logic [3:0]  shamt;
        logic [15:0] dbl;
        pos = 2'd0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (order[2*i +: 2] == k) begin
                pos = 2'(i);
            end
        end
        shamt = {1'b0, pos, 1'b0} + 4'd2;
        dbl   = {order, order} >> shamt;
        return dbl[7:0];
    endfunction

endpackage

`default_nettype wire

// File: rtl/dma_priority_encoder.sv
// ============================================================================
// Module : dma_priority_encoder
// Brief  : Picks the first pending channel walking the order from field [1:0] up.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module dma_priority_encoder
    import dma_pkg::*;
(
    input  logic [NUM_CH-1:0] pending,
    input  logic [7:0]        order,
    output logic [CH_W-1:0]   winner,
    output logic              any
);

    // Walk from lowest priority to highest so the highest pending entry is left.
    always_comb begin
        winner = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (pending[order[2*i +: CH_W]]) begin
                winner = order[2*i +: CH_W];
            end
        end
        any = |pending;
    end

endmodule

`default_nettype wire

// File: rtl/dma_priority_arbiter.sv
// ============================================================================
// Module : dma_priority_arbiter
// Brief  : 8237-style channel arbiter: request resolution, HRQ and DACK generation.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module dma_priority_arbiter
    import dma_pkg::*;
(
    input  logic              CLK,
    input  logic              RESET,
    input  logic [NUM_CH-1:0] DREQ,
    input  logic              dreqSense,
    input  logic              priorityType,
    input  logic              dmaDisable,
    input  logic [NUM_CH-1:0] maskReg,
    input  logic [NUM_CH-1:0] softReq,
    input  logic              HLDA,
    input  logic              assertDACK,
    input  logic              transferDone,
    output logic              hrqReq,
    output logic [NUM_CH-1:0] DACK,
    output logic [CH_W-1:0]   activeChannel,
    output logic              channelValid,
    output logic [NUM_CH-1:0] clearSoftReq,
    output logic [7:0]        priorityOrder
);

    arbState_t         state;
    arbState_t         state_next;
    logic [NUM_CH-1:0] pending;
    logic [CH_W-1:0]   winner;
    logic              any_pending;
    logic [CH_W-1:0]   active_ch;
    logic [NUM_CH-1:0] active_onehot;
    logic [NUM_CH-1:0] dack_q;
    logic [NUM_CH-1:0] clear_q;
    logic [7:0]        order_q;
    logic              service_done;

    assign pending       = ((DREQ ^ {NUM_CH{dreqSense}}) & ~maskReg) | softReq;
    assign active_onehot = 4'b0001 << active_ch;
    assign service_done  = (state == GRANT) && transferDone;

    dma_priority_encoder u_encoder (
        .pending (pending),
        .order   (order_q),
        .winner  (winner),
        .any     (any_pending)
    );

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (!dmaDisable && any_pending) begin
                    state_next = REQ;
                end
            end
            REQ: begin
                if (HLDA) begin
                    state_next = GRANT;
                end else if (!pending[active_ch] || dmaDisable) begin
                    state_next = IDLE;
                end
            end
            // A dropped HLDA without transferDone is an abort: no rotation, no clear.
            GRANT: begin
                if (transferDone || !HLDA) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        hrqReq        = (state != IDLE);
        channelValid  = (state != IDLE);
        DACK          = dack_q;
        clearSoftReq  = clear_q;
        activeChannel = active_ch;
        priorityOrder = order_q;
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            active_ch <= '0;
            dack_q    <= '0;
            clear_q   <= '0;
        end else begin
            if (state == IDLE && state_next == REQ) begin
                active_ch <= winner;
            end
            dack_q  <= (state == GRANT && state_next == GRANT && assertDACK) ? active_onehot : '0;
            clear_q <= (service_done && softReq[active_ch]) ? active_onehot : '0;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET || !priorityType) begin
            order_q <= ORDER_DEFAULT;
        end else if (service_done) begin
            order_q <= rotateOrder(order_q, active_ch);
        end
    end

endmodule

`default_nettype wire
